// File: rtl/instruction_fetch_decode_pkg.sv
// instruction_fetch_decode_pkg: opcodes and instruction field extractors shared by
// the fetch/decode front end and the execute stage.
package instruction_fetch_decode_pkg;
  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_JMP  = 4'h1,
    OP_BLE  = 4'h2,
    OP_ADD  = 4'h3,
    OP_STO  = 4'h4,
    OP_LED  = 4'h5,
    OP_IMUL = 4'h6
  } opcode_e;
  localparam int OPC_LSB  = 24;
  localparam int DEST_LSB = 16;
  localparam int SRC0_LSB = 8;
  localparam int SRC1_LSB = 0;
  function automatic logic [3:0] insn_opcode(input logic [27:0] insn);
    return insn[OPC_LSB +: 4];
  endfunction
  function automatic logic [7:0] insn_dest(input logic [27:0] insn);
    return insn[DEST_LSB +: 8];
  endfunction
  function automatic logic [7:0] insn_src0(input logic [27:0] insn);
    return insn[SRC0_LSB +: 8];
  endfunction
  function automatic logic [7:0] insn_src1(input logic [27:0] insn);
    return insn[SRC1_LSB +: 8];
  endfunction
  function automatic logic [15:0] insn_imm(input logic [27:0] insn);
    return insn[SRC1_LSB +: 16];
  endfunction
  function automatic logic [23:0] insn_delay(input logic [27:0] insn);
    return insn[SRC1_LSB +: 24];
  endfunction
endpackage

// File: rtl/instruction_fetch_decode_delay_counter.sv
// delay_counter: loadable down-counter; done flags the last idle cycle (count 1) or an empty load.
module delay_counter #(
  parameter int W = 24
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic         i_en,
  input  logic [W-1:0] i_value,
  output logic         o_done
);
  logic [W-1:0] r_count;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_count <= '0;
    else if (i_load) r_count <= i_value;
    else if (i_en && r_count != '0) r_count <= r_count - 1'b1;
  assign o_done = r_count <= W'(1);
endmodule

// File: rtl/instruction_fetch_decode.sv
// instruction_fetch_decode: fetches from a combinational ROM, resolves NOP/JMP/BLE locally
// and issues everything else to execute over a valid/ready handshake.
module instruction_fetch_decode
  import instruction_fetch_decode_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int INSN_W  = 28,
  parameter int DELAY_W = 24
) (
  input  logic              Clock,
  input  logic              Reset,
  output logic [ADDR_W-1:0] oAddress,
  input  logic [INSN_W-1:0] iInstruction,
  output logic              oValid,
  input  logic              iReady,
  output logic [3:0]        oOpcode,
  output logic [7:0]        oDest,
  output logic [7:0]        oSrc0,
  output logic [7:0]        oSrc1,
  output logic [15:0]       oImm,
  input  logic              iBranchValid,
  input  logic              iBranchTaken,
  output logic              oBusy
);
  typedef enum logic [1:0] {FETCH, NOP_WAIT, BR_WAIT} state_e;
  state_e              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_pc, r_target, w_pc_nxt, w_jump;
  logic                r_valid, w_valid_nxt, w_issue, w_load, w_done, w_fetch;
  logic [3:0]          r_opcode, w_opcode;
  logic [7:0]          r_dest, r_src0, r_src1;
  logic [15:0]         r_imm;
  logic [DELAY_W-1:0]  w_delay;
  assign w_opcode = insn_opcode(iInstruction);
  assign w_delay  = DELAY_W'(insn_delay(iInstruction));
  assign w_jump   = ADDR_W'(insn_dest(iInstruction));
  assign w_fetch  = r_state == FETCH && (!r_valid || iReady);
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_valid_nxt = r_valid && !iReady;
    w_issue     = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      FETCH: if (w_fetch) begin
        w_pc_nxt = r_pc + 1'b1;
        case (w_opcode)
          OP_NOP: begin
            w_load      = 1'b1;
            w_state_nxt = w_delay == '0 ? FETCH : NOP_WAIT;
          end
          OP_JMP: w_pc_nxt = w_jump;
          OP_BLE: begin
            w_issue     = 1'b1;
            w_valid_nxt = 1'b1;
            w_state_nxt = BR_WAIT;
          end
          default: begin
            w_issue     = 1'b1;
            w_valid_nxt = 1'b1;
          end
        endcase
      end
      NOP_WAIT: w_state_nxt = w_done ? FETCH : NOP_WAIT;
      BR_WAIT: if (iBranchValid) begin
        w_state_nxt = FETCH;
        w_pc_nxt    = iBranchTaken ? r_target : r_pc;
      end
      default: w_state_nxt = FETCH;
    endcase
  end
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      r_state  <= FETCH;
      r_pc     <= '0;
      r_valid  <= 1'b0;
      r_target <= '0;
      r_opcode <= '0;
      r_dest   <= '0;
      r_src0   <= '0;
      r_src1   <= '0;
      r_imm    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_valid <= w_valid_nxt;
      if (w_issue) begin
        r_target <= w_jump;
        r_opcode <= w_opcode;
        r_dest   <= insn_dest(iInstruction);
        r_src0   <= insn_src0(iInstruction);
        r_src1   <= insn_src1(iInstruction);
        r_imm    <= insn_imm(iInstruction);
      end
    end
  delay_counter #(.W(DELAY_W)) u_delay (
    .i_clk   (Clock),
    .i_rst_n (Reset),
    .i_load  (w_load),
    .i_en    (r_state == NOP_WAIT),
    .i_value (w_delay),
    .o_done  (w_done)
  );
  assign oAddress = r_pc;
  assign oValid   = r_valid;
  assign oOpcode  = r_opcode;
  assign oDest    = r_dest;
  assign oSrc0    = r_src0;
  assign oSrc1    = r_src1;
  assign oImm     = r_imm;
  assign oBusy    = r_state != FETCH;
endmodule

// File: doc/instruction_fetch_decode.md
# instruction_fetch_decode

- Sequencing front end that reads the program ROM.
- Drives the ROM address (program counter) and accepts the 28-bit instruction word returned combinationally in the same cycle.
- Splits each instruction into registered fields and resolves `NOP`, `JMP` and `BLE` control flow locally.
- Hands all other instructions to the execute stage over a valid/ready handshake.

## Interface
Parameters:
- `ADDR_W`, 16: program counter / ROM address width.
- `INSN_W`, 28: instruction width.
- `DELAY_W`, 24: NOP delay counter width.

Ports:
- `Clock` in 1: single clock, rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `oAddress` out 16: ROM address (PC).
- `iInstruction` in 28: ROM data, valid in the same cycle as `oAddress`.
- `oValid` out 1: decoded instruction present on the field outputs.
- `iReady` in 1: execute stage accepts the instruction when `oValid & iReady`.
- `oOpcode` out 4: bits [27:24].
- `oDest` out 8: bits [23:16].
- `oSrc0` out 8: bits [15:8].
- `oSrc1` out 8: bits [7:0].
- `oImm` out 16: bits [15:0].
- `iBranchValid` in 1: execute stage reports the `BLE` comparison result.
- `iBranchTaken` in 1: qualified by `iBranchValid`.
- `oBusy` out 1: high in `NOP_WAIT` or `BR_WAIT`.

## Operation
- States: `FETCH`, `NOP_WAIT`, `BR_WAIT`.
- Reset values: PC=0, state=`FETCH`, `oValid`=0, all field outputs 0, delay counter 0, `oBusy`=0.
- `FETCH`: an instruction is consumed only when the slot is free, i.e. `!oValid | iReady`. When the slot is not free, PC, fields and state all hold. On a consumed fetch, decode `iInstruction` by opcode:
  - **NOP**: load the counter with bits [23:0] (N). PC ← PC+1. `oValid` ← 0. If N=0 stay in `FETCH`, otherwise go to `NOP_WAIT`. The NOP is never issued.
  - **JMP**: PC ← {8'h00, bits[23:16]}. `oValid` ← 0. Stay in `FETCH`. Not issued.
  - **BLE**: register the fields, `oValid` ← 1, PC ← PC+1. Go to `BR_WAIT`. The target {8'h00, bits[23:16]} is captured internally.
  - **Others**: register the fields, `oValid` ← 1, PC ← PC+1.
- `NOP_WAIT`: the counter decrements every cycle. When it reaches 1, go to `FETCH`.
  - A delay of N produces exactly N idle cycles after the NOP fetch cycle.
  - `oValid` clears once the pending instruction is accepted.
- `BR_WAIT`: PC holds; no fetch.
  - When `iBranchValid` is sampled high: PC ← target if `iBranchTaken`, otherwise PC is unchanged (already PC+1). Go to `FETCH`.
  - If `iBranchValid` arrives in the same cycle the `BLE` is accepted, it is honoured.
- PC arithmetic is modulo 2^16: 0xFFFF+1 wraps to 0x0000.
- Opcodes not in the shared definitions are issued as ordinary instructions; the decode stage does not trap.
- Reset asserted in any state returns everything to the reset values immediately (asynchronous). The first fetch after deassertion reads address 0.

## Timing
- `oAddress` is registered; the ROM path is combinational, so the fetch decision uses `iInstruction` in the same cycle.
- Issue latency: an instruction at address A reaches the field outputs one cycle after PC=A is driven.
- Throughput: one instruction per cycle while `iReady`=1 and no control-flow instructions occur.
- Bubble cost:
  - JMP: 1 cycle.
  - NOP N: 1+N cycles.
  - BLE: 1 cycle plus branch-resolve wait.
- Field outputs are stable while `oValid & !iReady`.

## Structure
- Opcode constants (`NOP`, `JMP`, `BLE`, `ADD`, `STO`, `LED`, `IMUL`, …) and the field bit positions belong in the shared definitions header.
- The state encoding is local to this block.
- One natural sub-module: `delay_counter`. It is a loadable 24-bit down-counter with `load`, `en` and a `done` output (count==1 or loaded 0).

## Test plan
- Reset released, ROM returns non-control instructions at 0..3, `iReady`=1 → `oAddress` reads 0,1,2,3 on consecutive cycles; `oValid` goes high one cycle after address 0 and stays high; fields match bits.
- NOP with N=5 at address 0 → no `oValid` for 6 cycles; `oBusy` high 5 cycles; next fetch at address 1 on cycle 7.
- JMP with target 2 at address 16 → next `oAddress`=2; no issue of the JMP.
- BLE at address 11 with target 8: first `iBranchTaken`=1 → PC=8; second `iBranchTaken`=0 → PC=12. In both cases PC holds 12 while waiting on `iBranchValid`.
- `iReady` held low 3 cycles with `oValid`=1 → fields, PC and `oAddress` unchanged; resumes on release with no lost or duplicated instruction.
- PC=0xFFFF with a plain instruction → wraps to 0x0000.
- Reset pulsed mid-`NOP_WAIT` → `oValid`=0 and PC=0 asynchronously; the fetch restarts at address 0.
